// File: rtl/clock_edit_sequencer.sv
// Clock-setting front end: RUN/EDIT_SEC/EDIT_MIN/EDIT_HR sequencing, counter step strobes,
// inactivity timeout and field blink. Define CLOCK_EDIT_AUTO_REPEAT_EN for held-button repeat.
module clock_edit_sequencer #(
    parameter int unsigned TIMEOUT_TICKS = 3000,
    parameter int unsigned BLINK_TICKS   = 50,
    parameter int unsigned REPEAT_DELAY  = 60,
    parameter int unsigned REPEAT_PERIOD = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_set,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_ms_carryup,
    input  logic       i_sec_carryup,
    input  logic       i_min_carryup,
    output logic       o_ms_up,
    output logic       o_sec_up,
    output logic       o_sec_down,
    output logic       o_min_up,
    output logic       o_min_down,
    output logic       o_hr_up,
    output logic       o_hr_down,
    output logic [1:0] o_field,
    output logic       o_blink
);

    localparam int unsigned ToW = $clog2(TIMEOUT_TICKS) + 1;
    localparam int unsigned BlW = $clog2(BLINK_TICKS) + 1;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StEditSec = 2'b01,
        StEditMin = 2'b10,
        StEditHr  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     btn_q;
    logic           armed_q;
    logic [4:0]     btn_rise;
    logic           set_r, left_r, right_r, up_r, down_r;
    logic           any_rise, is_edit, move, step_up, step_dn, rep_fire;
    logic [ToW-1:0] inact_q, inact_d;
    logic [BlW-1:0] bcnt_q, bcnt_d;
    logic           blink_q, blink_d;
    logic [5:0]     pulse_q, pulse_d; // {sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn}

    // armed_q masks the first post-reset cycle so levels held through reset are not edges
    assign btn_rise = {i_set, i_left, i_right, i_up, i_down} & ~btn_q & {5{armed_q}};
    assign {set_r, left_r, right_r, up_r, down_r} = btn_rise;
    assign any_rise = |btn_rise;
    assign is_edit  = (state_q != StRun);

`ifdef CLOCK_EDIT_AUTO_REPEAT_EN
    localparam int unsigned RpMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RpW   = $clog2(RpMax) + 1;

    logic [RpW-1:0] rcnt_q, rcnt_d, rlimit;
    logic           rphase_q, rphase_d;

    always_comb begin
        rcnt_d   = rcnt_q;
        rphase_d = rphase_q;
        rep_fire = 1'b0;
        rlimit   = rphase_q ? RpW'(REPEAT_PERIOD) : RpW'(REPEAT_DELAY);
        if (!is_edit || any_rise || !(i_up ^ i_down)) begin
            rcnt_d   = '0;
            rphase_d = 1'b0;
        end else if (i_tick) begin
            if (rcnt_q + 1'b1 == rlimit) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
                rphase_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rcnt_q   <= '0;
            rphase_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rphase_q <= rphase_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        move    = 1'b0;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (is_edit) begin
            if (set_r) begin
                state_d = StRun;
            end else if (left_r ^ right_r) begin
                move = 1'b1;
                unique case (state_q)
                    StEditSec: state_d = right_r ? StEditMin : StEditHr;
                    StEditMin: state_d = right_r ? StEditHr : StEditSec;
                    default:   state_d = right_r ? StEditSec : StEditMin;
                endcase
            end else if (!left_r && !right_r) begin
                step_up = (up_r && !down_r) || (rep_fire && i_up);
                step_dn = (down_r && !up_r) || (rep_fire && i_down);
            end
            if (!any_rise && !rep_fire && i_tick && (inact_q == ToW'(TIMEOUT_TICKS - 1))) begin
                state_d = StRun;
            end
        end else if (set_r) begin
            state_d = StEditSec;
        end

        pulse_d = '0;
        unique case (state_q)
            StEditSec: pulse_d[5:4] = {step_up, step_dn};
            StEditMin: pulse_d[3:2] = {step_up, step_dn};
            StEditHr:  pulse_d[1:0] = {step_up, step_dn};
            default:   pulse_d      = '0;
        endcase

        inact_d = inact_q;
        if (state_d == StRun || !is_edit || any_rise || rep_fire) begin
            inact_d = '0;
        end else if (i_tick) begin
            inact_d = inact_q + 1'b1;
        end

        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (state_d == StRun) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (!is_edit || move) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (i_tick) begin
            if (bcnt_q == BlW'(BLINK_TICKS - 1)) begin
                blink_d = ~blink_q;
                bcnt_d  = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StRun;
            btn_q   <= '0;
            armed_q <= 1'b0;
            inact_q <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= {i_set, i_left, i_right, i_up, i_down};
            armed_q <= 1'b1;
            inact_q <= inact_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            pulse_q <= pulse_d;
        end
    end

    // Time runs only in RUN; edit-mode strobes come from the registered pulses
    assign o_ms_up    = !is_edit && i_tick;
    assign o_sec_up   = is_edit ? pulse_q[5] : i_ms_carryup;
    assign o_sec_down = pulse_q[4];
    assign o_min_up   = is_edit ? pulse_q[3] : i_sec_carryup;
    assign o_min_down = pulse_q[2];
    assign o_hr_up    = is_edit ? pulse_q[1] : i_min_carryup;
    assign o_hr_down  = pulse_q[0];
    assign o_field    = state_q;
    assign o_blink    = blink_q;

endmodule

// File: tb/tb_clock_edit_sequencer.sv
// Bench for clock_edit_sequencer: directed scenarios and random traffic, every cycle compared
// against a behavioural model of the field/step/timeout/blink rules.
`timescale 1ns/1ps
module tb_clock_edit_sequencer;
    localparam int TO = 3000;
    localparam int BL = 50;
`ifdef CLOCK_EDIT_AUTO_REPEAT_EN
    localparam int RD = 60;
    localparam int RP = 10;
`endif
    // strobe bit positions in the observed vector
    localparam int C_MS = 6, C_SECU = 5, C_SECD = 4, C_MINU = 3, C_MIND = 2, C_HRU = 1, C_HRD = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tick, set_b, left_b, right_b, up_b, down_b, msc, secc, minc;
    logic ms_up, sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn, blink;
    logic [1:0] field;

    clock_edit_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick),
        .i_set(set_b), .i_left(left_b), .i_right(right_b), .i_up(up_b), .i_down(down_b),
        .i_ms_carryup(msc), .i_sec_carryup(secc), .i_min_carryup(minc),
        .o_ms_up(ms_up), .o_sec_up(sec_up), .o_sec_down(sec_dn), .o_min_up(min_up),
        .o_min_down(min_dn), .o_hr_up(hr_up), .o_hr_down(hr_dn), .o_field(field), .o_blink(blink)
    );

    int nchk = 0, nerr = 0, ncyc = 0;
    int cnt[7];

    int m_field, m_inact, m_bcnt, m_pend, m_rcnt, m_rphase;
    bit m_blink, m_armed, m_valid;
    bit m_prev[5];

    task automatic model_expect(output logic [9:0] e);
        logic [6:0] s;
        s = '0;
        if (m_field == 0) begin
            s[C_MS] = tick; s[C_SECU] = msc; s[C_MINU] = secc; s[C_HRU] = minc;
        end else if (m_pend >= 0) begin
            s[m_pend] = 1'b1;
        end
        e = {2'(m_field), m_blink, s};
    endtask

    task automatic model_step();
        bit b[5];
        bit r[5];
        bit anyr, rfire, move;
        int nf, pend;
`ifdef CLOCK_EDIT_AUTO_REPEAT_EN
        bit held;
`endif
        b = '{set_b, left_b, right_b, up_b, down_b};
        m_valid = 1'b1;
        if (rst) begin
            m_field = 0; m_inact = 0; m_bcnt = 0; m_pend = -1; m_rcnt = 0; m_rphase = 0;
            m_blink = 1'b0; m_armed = 1'b0; m_prev = '{default: 1'b0};
            return;
        end
        anyr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r[i] = m_armed && b[i] && !m_prev[i];
            anyr |= r[i];
        end
        rfire = 1'b0;
`ifdef CLOCK_EDIT_AUTO_REPEAT_EN
        held = up_b ^ down_b;
        if (m_field == 0 || anyr || !held) begin
            m_rcnt = 0; m_rphase = 0;
        end else if (tick) begin
            m_rcnt++;
            if (m_rcnt == (m_rphase != 0 ? RP : RD)) begin
                rfire = 1'b1; m_rcnt = 0; m_rphase = 1;
            end
        end
`endif
        nf = m_field; move = 1'b0; pend = -1;
        if (m_field == 0) begin
            if (r[0]) nf = 1;
        end else if (r[0]) begin
            nf = 0;
        end else if (r[1] != r[2]) begin
            move = 1'b1;
            nf = r[2] ? (m_field % 3) + 1 : ((m_field + 1) % 3) + 1;
        end else if (!r[1] && !r[2]) begin
            if ((r[3] && !r[4]) || (rfire && up_b)) pend = 7 - 2 * m_field;
            else if ((r[4] && !r[3]) || (rfire && down_b)) pend = 6 - 2 * m_field;
        end
        if (m_field != 0 && !anyr && !rfire && tick && m_inact == TO - 1) nf = 0;

        if (nf == 0 || m_field == 0 || anyr || rfire) m_inact = 0;
        else if (tick) m_inact++;

        if (nf == 0) begin
            m_blink = 1'b0; m_bcnt = 0;
        end else if (m_field == 0 || move) begin
            m_blink = 1'b1; m_bcnt = 0;
        end else if (tick) begin
            if (m_bcnt == BL - 1) begin
                m_blink = ~m_blink; m_bcnt = 0;
            end else begin
                m_bcnt++;
            end
        end
        m_pend = pend; m_field = nf; m_prev = b; m_armed = 1'b1;
    endtask

    // Inputs are driven at the falling edge; outputs sampled 1ns later.
    task automatic cyc();
        logic [9:0] e, o;
        #1;
        o = {field, blink, ms_up, sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn};
        if (m_valid) begin
            model_expect(e);
            nchk++;
            assert (o === e) else begin
                nerr++;
                $error("FAIL model cyc=%0d obs=%b exp=%b", ncyc, o, e);
            end
        end
        for (int i = 0; i < 7; i++) cnt[i] += int'(o[i] === 1'b1);
        model_step();
        ncyc++;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 7; i++) cnt[i] = 0;
    endtask

    function automatic int strobes();
        int s = 0;
        for (int i = 0; i < 7; i++) s += cnt[i];
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic set_btn(input int k, input logic v);
        case (k)
            0: set_b = v;
            1: left_b = v;
            2: right_b = v;
            3: up_b = v;
            default: down_b = v;
        endcase
    endtask

    task automatic press(input int k);
        set_btn(k, 1'b1); cyc();
        set_btn(k, 1'b0); cyc();
    endtask

    initial begin
        {rst, tick, set_b, left_b, right_b, up_b, down_b, msc, secc, minc} = '0;
        m_valid = 1'b0; m_pend = -1; m_field = 0;
        clr_cnt();
        rst = 1'b1;
        @(negedge clk);
        idle(3);
        check("rst_field", field, 0);
        check("rst_blink", blink, 0);
        check("rst_strobes", {ms_up, sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn}, 0);
        rst = 1'b0;
        idle(2);

        // 100 ticks with a ms carry on the last one
        clr_cnt();
        for (int t = 1; t <= 100; t++) begin
            tick = 1'b1; msc = (t == 100); cyc();
            tick = 1'b0; msc = 1'b0; cyc();
        end
        check("run_ms_up", cnt[C_MS], 100);
        check("run_sec_up", cnt[C_SECU], 1);
        check("run_field", field, 0);

        // set, right x2, up
        clr_cnt();
        press(0); check("enter_field", field, 1); check("enter_blink", blink, 1);
        press(2); check("right1_field", field, 2);
        press(2); check("right2_field", field, 3);
        press(3); idle(1);
        ticks(5);
        check("hr_up_once", cnt[C_HRU], 1);
        check("edit_ms_frozen", cnt[C_MS], 0);
        check("edit_total", strobes(), 1);

        // simultaneous edges
        press(1); check("left_to_min", field, 2);
        clr_cnt();
        up_b = 1'b1; down_b = 1'b1; cyc();
        up_b = 1'b0; down_b = 1'b0; idle(2);
        check("updown_same", strobes(), 0);
        left_b = 1'b1; up_b = 1'b1; cyc();
        left_b = 1'b0; up_b = 1'b0; idle(2);
        check("left_up_field", field, 1);
        check("left_up_nostep", strobes(), 0);
        press(0); check("exit_field", field, 0);

        // inactivity timeout
        press(0);
        ticks(2999); check("to_2999_field", field, 1);
        ticks(1); check("to_3000_field", field, 0); check("to_blink", blink, 0);
        press(0);
        ticks(2999); press(2); check("to_restart_move", field, 2);
        ticks(2999); check("to_restart_hold", field, 2);
        ticks(1); check("to_restart_exit", field, 0);

        // held up in EDIT_SEC for 80 ticks
        press(0);
        clr_cnt();
        up_b = 1'b1; cyc();
        ticks(80);
        up_b = 1'b0; idle(3);
`ifdef CLOCK_EDIT_AUTO_REPEAT_EN
        check("hold_sec_up", cnt[C_SECU], 4);
`else
        check("hold_sec_up", cnt[C_SECU], 1);
`endif
        check("hold_sec_dn", cnt[C_SECD], 0);
        press(0);

        // reset mid-edit with up held
        press(0); press(1); check("hr_field", field, 3);
        up_b = 1'b1; idle(3);
        clr_cnt();
        rst = 1'b1; cyc();
        check("rst_mid_field", field, 0);
        idle(2);
        rst = 1'b0; idle(4);
        check("rst_mid_hr_up", cnt[C_HRU], 0);
        check("rst_mid_total", strobes(), 0);
        up_b = 1'b0; idle(2);
        press(0); check("post_rst_enter", field, 1);
        press(0);

        // random traffic; second half holds buttons much longer
        for (int i = 0; i < 4000; i++) begin
            int pset, pud;
            pset = (i < 2000) ? 40 : 800;
            pud  = (i < 2000) ? 16 : 400;
            if ($urandom_range(pset - 1) == 0) set_b = ~set_b;
            if ($urandom_range(30) == 0) left_b = ~left_b;
            if ($urandom_range(30) == 0) right_b = ~right_b;
            if ($urandom_range(pud - 1) == 0) up_b = ~up_b;
            if ($urandom_range(pud - 1) == 0) down_b = ~down_b;
            tick = ($urandom_range(2) == 0);
            msc  = ($urandom_range(7) == 0);
            secc = ($urandom_range(7) == 0);
            minc = ($urandom_range(7) == 0);
            rst  = ($urandom_range(599) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
